// File: rtl/uart_pkg.sv
// Shared UART definitions: default frame constants and the transmitter
// state encoding. The receiver and the baud generator use the same constants.
package uart_pkg;

  // Default frame geometry
  localparam int UART_NB_DATA = 8;
  localparam int UART_N_OS    = 16;
  localparam int UART_SB_TICK = 16;

  // Transmitter state encoding (3-bit, legacy-compatible constants)
  typedef logic [2:0] uart_state_t;

  localparam uart_state_t ST_IDLE   = 3'd0;
  localparam uart_state_t ST_START  = 3'd1;
  localparam uart_state_t ST_DATA   = 3'd2;
  localparam uart_state_t ST_PARITY = 3'd3;
  localparam uart_state_t ST_STOP   = 3'd4;

  // Larger of two integers, for sizing counters shared by several bit types
  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  // Counter width able to hold 0..n-1; never narrower than one bit
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/alu_uart_tx.sv
// UART transmitter for ALU results. Sends one NB_DATA-bit word per request,
// LSB first, framed by a start bit and SB_TICK ticks of stop level. Bit timing
// comes from an external 16x oversampling tick.
// Optional build macro UART_TX_PARITY_EN inserts an even-parity bit between
// the MSB and the stop bit.
module alu_uart_tx
  import uart_pkg::*;
#(
  parameter int NB_DATA = UART_NB_DATA,
  parameter int SB_TICK = UART_SB_TICK,
  parameter int N_OS    = UART_N_OS
) (
  input  logic               clk,
  input  logic               i_rst_n,
  input  logic               i_tick,
  input  logic               i_tx_start,
  input  logic [NB_DATA-1:0] i_tx_data,
  output logic               o_tx,
  output logic               o_tx_busy,
  output logic               o_tx_done_tick
);

  localparam int TW = cnt_w(max2(N_OS, SB_TICK));
  localparam int BW = cnt_w(NB_DATA);

  localparam logic [TW-1:0] OS_LAST  = TW'(N_OS - 1);
  localparam logic [TW-1:0] SB_LAST  = TW'(SB_TICK - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(NB_DATA - 1);

  uart_state_t        state;
  logic [TW-1:0]      tick_cnt;
  logic [BW-1:0]      bit_cnt;
  logic [NB_DATA-1:0] shreg;
  logic [NB_DATA-1:0] shreg_nxt;
  logic               tx_r;
  logic               busy_r;
  logic               done_r;
`ifdef UART_TX_PARITY_EN
  logic               par_r;
`endif

  // Next shift-register contents once the current data bit has been sent
  always_comb begin
    shreg_nxt = shreg >> 1;
  end

`ifdef UART_TX_PARITY_EN
  // Even parity of the word, captured at acceptance because the shift
  // register is consumed while the data bits go out
  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      par_r <= 1'b0;
    end else if (state == ST_IDLE && i_tx_start) begin
      par_r <= ^i_tx_data;
    end
  end
`endif

  // Frame sequencer: every output is registered, so the line level for a bit
  // is loaded on the same edge that enters that bit's state
  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state    <= ST_IDLE;
      tick_cnt <= '0;
      bit_cnt  <= '0;
      shreg    <= '0;
      tx_r     <= 1'b1;
      busy_r   <= 1'b0;
      done_r   <= 1'b0;
    end else begin
      done_r <= 1'b0;
      case (state)
        ST_IDLE: begin
          tx_r   <= 1'b1;
          busy_r <= 1'b0;
          if (i_tx_start) begin
            shreg    <= i_tx_data;
            tick_cnt <= '0;
            bit_cnt  <= '0;
            tx_r     <= 1'b0;
            busy_r   <= 1'b1;
            state    <= ST_START;
          end
        end

        ST_START: begin
          if (i_tick) begin
            if (tick_cnt == OS_LAST) begin
              tick_cnt <= '0;
              bit_cnt  <= '0;
              tx_r     <= shreg[0];
              state    <= ST_DATA;
            end else begin
              tick_cnt <= tick_cnt + TW'(1);
            end
          end
        end

        ST_DATA: begin
          if (i_tick) begin
            if (tick_cnt == OS_LAST) begin
              tick_cnt <= '0;
              shreg    <= shreg_nxt;
              if (bit_cnt == BIT_LAST) begin
                bit_cnt <= '0;
`ifdef UART_TX_PARITY_EN
                tx_r    <= par_r;
                state   <= ST_PARITY;
`else
                tx_r    <= 1'b1;
                state   <= ST_STOP;
`endif
              end else begin
                bit_cnt <= bit_cnt + BW'(1);
                tx_r    <= shreg_nxt[0];
              end
            end else begin
              tick_cnt <= tick_cnt + TW'(1);
            end
          end
        end

`ifdef UART_TX_PARITY_EN
        ST_PARITY: begin
          if (i_tick) begin
            if (tick_cnt == OS_LAST) begin
              tick_cnt <= '0;
              tx_r     <= 1'b1;
              state    <= ST_STOP;
            end else begin
              tick_cnt <= tick_cnt + TW'(1);
            end
          end
        end
`endif

        ST_STOP: begin
          // The done pulse occupies one extra STOP cycle so that a start
          // request coinciding with it is still seen as busy and dropped.
          if (done_r) begin
            busy_r <= 1'b0;
            state  <= ST_IDLE;
          end else if (i_tick) begin
            if (tick_cnt == SB_LAST) begin
              tick_cnt <= '0;
              done_r   <= 1'b1;
            end else begin
              tick_cnt <= tick_cnt + TW'(1);
            end
          end
        end

        default: begin
          tick_cnt <= '0;
          bit_cnt  <= '0;
          tx_r     <= 1'b1;
          busy_r   <= 1'b0;
          state    <= ST_IDLE;
        end
      endcase
    end
  end

  assign o_tx           = tx_r;
  assign o_tx_busy      = busy_r;
  assign o_tx_done_tick = done_r;

endmodule
